rv32i_fetch_buffer: RTL and testbench

//  Instruction-fetch front end that feeds the decode stage of the RV32i pipeline datapath.
//  - Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
//  - Buffers returned words with their PCs in a small in-order FIFO.
//  - Presents one instruction per cycle to decode and absorbs decode stalls.
//  - Accepts a PC redirect from jumps/branches; on redirect it flushes all fetched and in-flight words.

---
 rtl/rv32i_fetch_buffer_pkg.sv | 13 +
 rtl/rv32i_fetch_buffer_fetch_fifo.sv | 80 ++++++++
 rtl/rv32i_fetch_buffer.sv | 143 ++++++++++++++
 tb/tb_rv32i_fetch_buffer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_fetch_buffer_pkg.sv
// Shared types and constants for the RV32i instruction-fetch front end.
package rv32i_fetch_buffer_pkg;

    // Canonical RV32I no-op (addi x0, x0, 0), shown to decode when no instruction is valid.
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_buffer_fetch_fifo.sv
// Small in-order FIFO with synchronous flush; the head entry is visible combinationally.
// A push and a pop in the same cycle are legal when full (the popped slot is refilled).
module fetch_fifo
    import rv32i_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = fetch_entry_t
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output T                         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Next-state pointers and occupancy; flush wins over any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until pushed, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    a_no_overflow:  assert property (@(posedge clk_i) disable iff (reset_i)
                                     !(push_i && !pop_i && !flush_i && full_o));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
                                     !(pop_i && !flush_i && empty_o));

endmodule

// File: rtl/rv32i_fetch_buffer.sv
// Instruction-fetch front end for the RV32i pipeline: owns the fetch PC, issues
// instruction-memory requests, buffers returned words with their PCs and hands
// one instruction per cycle to decode.
//
// Handshakes:
//  - Memory side: a request is issued on a cycle where imem_req_o && imem_gnt_i;
//    req and address are held while gnt is low. Each issued request is answered by
//    exactly one imem_rvalid_i pulse, in issue order, at least one cycle later.
//  - Decode side: inst_valid_o is the valid; !stall_i && !redirect_i is the ready.
//    An instruction is consumed on a cycle where inst_valid_o && !stall_i && !redirect_i.
//  - A redirect flushes buffered words and marks every in-flight request to be dropped.
module rv32i_fetch_buffer
    import rv32i_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_add_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW:0]   occupancy;

    logic          issue, push, pop;
    fetch_entry_t  push_entry, head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   pcq_head;
    logic          pcq_full, pcq_empty;
    logic [CW-1:0] pcq_count;

    // Request only when every possible response already has a FIFO slot reserved.
    always_comb begin
        occupancy  = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req_o = !reset_i && !redirect_i && (occupancy < DEPTH_OCC);
        imem_add_o = fetch_pc_q;
        issue      = imem_req_o && imem_gnt_i;
        push       = imem_rvalid_i && !redirect_i && (drop_q == '0);
        pop        = !fifo_empty && !stall_i && !redirect_i;
        push_entry = '{pc: pcq_head, inst: imem_data_i};
    end

    // Fetch PC, in-flight count and drop count; a redirect overrides everything.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (issue)         outstanding_d = outstanding_d + ONE;
        if (imem_rvalid_i) outstanding_d = outstanding_d - ONE;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            drop_d     = imem_rvalid_i ? (outstanding_q - ONE) : outstanding_q;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - ONE;
        end
    end

    // Front-end state registers, reset asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Buffered instructions waiting for decode.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_entry_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Addresses of in-flight requests. Never flushed: dropped responses still pop
    // their address, which keeps this queue aligned with the memory's reply stream.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [31:0])
    ) u_pc_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (issue),
        .data_i  (fetch_pc_q),
        .pop_i   (imem_rvalid_i),
        .flush_i (1'b0),
        .head_o  (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    // Decode-facing outputs straight from the FIFO head; NOP / PC 0 when empty.
    always_comb begin
        inst_valid_o = !fifo_empty;
        inst_o       = fifo_empty ? RV32I_NOP : head.inst;
        pc_o         = fifo_empty ? 32'h0000_0000 : head.pc;
        pc_plus4_o   = pc_o + 32'd4;
    end

    a_entry_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
                                          !(push && !pop && fifo_full));
    a_pcq_no_overflow:   assert property (@(posedge clk_i) disable iff (reset_i)
                                          !(issue && pcq_full && !imem_rvalid_i));
    a_rvalid_expected:   assert property (@(posedge clk_i) disable iff (reset_i)
                                          !(imem_rvalid_i && pcq_empty));
    a_pcq_tracks_out:    assert property (@(posedge clk_i) disable iff (reset_i)
                                          pcq_count == outstanding_q);

endmodule

// File: tb/tb_rv32i_fetch_buffer.sv
// Self-checking bench for rv32i_fetch_buffer: an instruction-memory model answers
// grants in order, and a scoreboard of {pc, inst} entries predicts what decode sees.
module tb_rv32i_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_add_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    rv32i_fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .imem_req_o    (imem_req_o),
        .imem_add_o    (imem_add_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_data_i   (imem_data_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard and models ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } infl_t;

    logic [63:0] exp_q[$];       // {pc, inst} for live fetches, oldest first
    infl_t       infl[$];        // memory model: granted, not yet answered
    logic [31:0] exp_fetch_pc;
    bit          cur_stale;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    // stimulus plan
    bit          plan_gnt, plan_stall, plan_redir;
    logic [31:0] plan_redir_pc;
    bit          rnd_gnt, rnd_stall, rnd_redir;
    int          lat_lo, lat_hi;
    int          redir_mode;     // 0 none, 1 when >=2 live in flight and FIFO non-empty, 2 on rvalid+pop
    logic [31:0] redir_target;
    int          redir_hits;

    // observations
    int          rel_cyc, first_lat;
    bit          first_seen;
    bit          watch;
    logic [31:0] watch_exp;
    int          wrap_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_counts(output int live, output int stale, output int fifo_n);
        live  = 0;
        stale = 0;
        foreach (infl[i]) begin
            if (infl[i].stale) stale++;
            else               live++;
        end
        if (imem_rvalid_i) begin
            if (cur_stale) stale++;
            else           live++;
        end
        fifo_n = exp_q.size() - live;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req_o},   32'd0);
        check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
        check({tag, "_inst"},  inst_o,                NOP);
        check({tag, "_pc"},    pc_o,                  32'h0);
        check({tag, "_pc4"},   pc_plus4_o,            32'h4);
    endtask

    // ---------------- driver: runs just after the rising edge ----------------
    task automatic drive();
        int live, stale, fifo_n;
        cyc++;
        imem_gnt_i    = rnd_gnt   ? ($urandom_range(0, 99) < 70) : plan_gnt;
        stall_i       = rnd_stall ? ($urandom_range(0, 99) < 30) : plan_stall;
        redirect_i    = plan_redir;
        redirect_pc_i = plan_redir_pc;
        if (rnd_redir && ($urandom_range(0, 99) < 5)) begin
            redirect_i    = 1'b1;
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 3))
                                                        : 32'($urandom);
        end
        imem_rvalid_i = 1'b0;
        imem_data_i   = 32'($urandom);
        cur_stale     = 1'b0;
        if (infl.size() > 0 && infl[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_data_i   = mem_word(infl[0].addr);
            cur_stale     = infl[0].stale;
            void'(infl.pop_front());
        end
        model_counts(live, stale, fifo_n);
        if ((redir_mode == 1 && live >= 2 && fifo_n >= 1) ||
            (redir_mode == 2 && imem_rvalid_i && !cur_stale && inst_valid_o && !stall_i)) begin
            redirect_i    = 1'b1;
            redirect_pc_i = redir_target;
            redir_hits++;
            redir_mode    = 0;
        end
    endtask

    // ---------------- monitor: runs on the falling edge ----------------
    task automatic monitor();
        int          live, stale, fifo_n;
        bit          exp_req, exp_valid;
        logic [63:0] e;
        model_counts(live, stale, fifo_n);
        exp_req   = !redirect_i && ((exp_q.size() + stale) < DEPTH);
        exp_valid = (fifo_n > 0);
        check("req",   {31'd0, imem_req_o},   {31'd0, exp_req});
        check("valid", {31'd0, inst_valid_o}, {31'd0, exp_valid});
        if (exp_req) check("addr", imem_add_o, exp_fetch_pc);
        if (exp_valid) begin
            e = exp_q[0];
            check("pc",   pc_o,       e[63:32]);
            check("inst", inst_o,     e[31:0]);
            check("pc4",  pc_plus4_o, e[63:32] + 32'd4);
        end else begin
            check("nop", inst_o, NOP);
        end
        if (!first_seen && inst_valid_o) begin
            first_seen = 1'b1;
            first_lat  = cyc - rel_cyc;
        end
        if (!redirect_i && watch && inst_valid_o) begin
            check("redir_target_pc", pc_o, watch_exp);
            watch = 1'b0;
        end
        // advance models to the state after the coming rising edge
        if (redirect_i) begin
            exp_q.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            exp_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
            watch        = 1'b1;
            watch_exp    = exp_fetch_pc;
        end else begin
            if (imem_req_o && imem_gnt_i) begin
                infl.push_back('{addr: imem_add_o,
                                 due: cyc + 1 + int'($urandom_range(lat_lo, lat_hi)),
                                 stale: 1'b0});
                exp_q.push_back({exp_fetch_pc, mem_word(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            if (exp_valid && !stall_i) begin
                e = exp_q.pop_front();
                if (e[63:32] == 32'hFFFF_FFFC) wrap_seen++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        drive();
        @(negedge clk_i);
        monitor();
    endtask

    task automatic release_reset();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        drive();
        rel_cyc    = cyc;
        first_seen = 1'b0;
        @(negedge clk_i);
        monitor();
    endtask

    task automatic clear_models();
        exp_q.delete();
        infl.delete();
        exp_fetch_pc  = 32'h0;
        cur_stale     = 1'b0;
        watch         = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        reset_i = 1'b1;
        imem_data_i = 32'h0; redirect_pc_i = 32'h0;
        plan_gnt = 1'b1; plan_stall = 1'b0; plan_redir = 1'b0; plan_redir_pc = 32'h0;
        rnd_gnt = 1'b0; rnd_stall = 1'b0; rnd_redir = 1'b0;
        lat_lo = 0; lat_hi = 0; redir_mode = 0; redir_target = 32'h0; redir_hits = 0;
        first_seen = 1'b0; first_lat = -1; rel_cyc = 0; wrap_seen = 0;
        clear_models();

        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("por");

        // streaming fetch, one-cycle memory
        release_reset();
        repeat (20) step();
        check("first_valid_latency", 32'(first_lat), 32'd2);

        // decode stall for 5 cycles, then release
        plan_stall = 1'b1;
        repeat (5) step();
        plan_stall = 1'b0;
        repeat (10) step();

        // grant withheld for 3 cycles with request high
        plan_gnt = 1'b0;
        repeat (3) step();
        plan_gnt = 1'b1;
        repeat (6) step();

        // redirect to 0x102 with 2 live requests in flight and FIFO non-empty
        lat_lo = 2; lat_hi = 2;
        plan_stall   = 1'b1;
        redir_target = 32'h0000_0102;
        redir_mode   = 1;
        for (int i = 0; i < 40 && redir_mode != 0; i++) step();
        check("redir_busy_fired", 32'(redir_hits), 32'd1);
        plan_stall = 1'b0;
        lat_lo = 0; lat_hi = 0;
        repeat (12) step();

        // redirect colliding with a response and a would-be pop
        lat_lo = 0; lat_hi = 1;
        redir_target = 32'h0000_0400;
        redir_mode   = 2;
        for (int i = 0; i < 60 && redir_mode != 0; i++) step();
        check("redir_collide_fired", 32'(redir_hits), 32'd2);
        repeat (12) step();

        // fetch PC wrap at the top of the address space
        lat_lo = 0; lat_hi = 0;
        plan_redir = 1'b1; plan_redir_pc = 32'hFFFF_FFF8;
        step();
        plan_redir = 1'b0;
        repeat (12) step();
        check("wrap_seen", 32'(wrap_seen), 32'd1);

        // random traffic: grants, stalls, latency and redirects all vary
        rnd_gnt = 1'b1; rnd_stall = 1'b1; rnd_redir = 1'b1;
        lat_lo = 0; lat_hi = 2;
        repeat (400) step();
        rnd_gnt = 1'b0; rnd_stall = 1'b0; rnd_redir = 1'b0;
        plan_gnt = 1'b1; lat_lo = 0; lat_hi = 0;
        repeat (4) step();

        // asynchronous reset mid-stream, between clock edges
        @(posedge clk_i);
        #3;
        reset_i = 1'b1;
        #1;
        check_reset_outputs("async");
        clear_models();
        repeat (2) @(posedge clk_i);
        release_reset();
        repeat (15) step();
        check("restart_latency", 32'(first_lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
